// File: rtl/gpu_sprite_regs_pkg.sv
// Shared constants and types for the sprite register block: register map,
// sprite geometry, CTRL/STATUS bit positions and the power-on bitmap.
package gpu_pkg;

  localparam int SPRITE_W = 5;
  localparam int SPRITE_H = 5;
  localparam int COORD_W  = 11;

  localparam logic [3:0] REG_XLO    = 4'h0;
  localparam logic [3:0] REG_XHI    = 4'h1;
  localparam logic [3:0] REG_YLO    = 4'h2;
  localparam logic [3:0] REG_YHI    = 4'h3;
  localparam logic [3:0] REG_ROW0   = 4'h4;
  localparam logic [3:0] REG_ROW1   = 4'h5;
  localparam logic [3:0] REG_ROW2   = 4'h6;
  localparam logic [3:0] REG_ROW3   = 4'h7;
  localparam logic [3:0] REG_ROW4   = 4'h8;
  localparam logic [3:0] REG_CTRL   = 4'h9;
  localparam logic [3:0] REG_STATUS = 4'hA;

  localparam int CTRL_COMMIT_BIT   = 0;
  localparam int CTRL_IRQ_EN_BIT   = 1;
  localparam int STAT_PENDING_BIT  = 0;
  localparam int STAT_VBLANK_BIT   = 1;
  localparam int STAT_IRQ_BIT      = 7;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SPRITE_H-1:0][SPRITE_W-1:0] sprite_bmp_t;

  // Row 0 sits in the lowest slot; bit 0 of each row is the leftmost pixel.
  localparam sprite_bmp_t SPRITE_DEFAULT = {5'b10001, 5'b10001, 5'b11111, 5'b10000, 5'b10000};

  // Off-screen coordinates park the sprite at the origin.
  function automatic coord_t wrap_coord(input coord_t v, input int unsigned limit);
    if (32'(v) >= limit) begin
      return {COORD_W{1'b0}};
    end else begin
      return v;
    end
  endfunction

endpackage

// File: rtl/gpu_sprite_regs_if.sv
// 6502-side bus bundle for the sprite register block.
interface gpu_sprite_regs_if;
  logic       PHI2;
  logic       CS_N;
  logic       RW;
  logic [3:0] ADDR;
  logic [7:0] DATA_IN;
  logic [7:0] DATA_OUT;
  logic       DATA_OE;

  modport master (output PHI2, CS_N, RW, ADDR, DATA_IN, input DATA_OUT, DATA_OE);
  modport slave  (input PHI2, CS_N, RW, ADDR, DATA_IN, output DATA_OUT, DATA_OE);
endinterface

// File: rtl/gpu_bus_sync.sv
// Brings the asynchronous 6502 bus into the pixel clock domain and turns each
// bus cycle into a single write or read strobe on the synced PHI2 falling edge.
module gpu_bus_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       phi2,
  input  logic       cs_n,
  input  logic       rw,
  input  logic [3:0] bus_addr,
  input  logic [7:0] bus_data,
  output logic       wr_stb,
  output logic       rd_stb,
  output logic [3:0] addr,
  output logic [7:0] data
);

  logic [SYNC_STAGES-1:0] phi2_sync_r;
  logic [SYNC_STAGES-1:0] cs_n_sync_r;
  logic [SYNC_STAGES-1:0] rw_sync_r;
  logic                   phi2_prev_r;
  logic [3:0]             addr_r;
  logic [7:0]             data_r;
  logic                   phi2_s;
  logic                   done_s;

  assign phi2_s = phi2_sync_r[SYNC_STAGES-1];
  assign done_s = phi2_prev_r & ~phi2_s & ~cs_n_sync_r[SYNC_STAGES-1];

  // Synchronisers idle as "no access"; address/data track the bus while PHI2 is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phi2_sync_r <= {SYNC_STAGES{1'b0}};
      cs_n_sync_r <= {SYNC_STAGES{1'b1}};
      rw_sync_r   <= {SYNC_STAGES{1'b1}};
      phi2_prev_r <= 1'b0;
      addr_r      <= 4'h0;
      data_r      <= 8'h00;
    end else begin
      phi2_sync_r <= {phi2_sync_r[SYNC_STAGES-2:0], phi2};
      cs_n_sync_r <= {cs_n_sync_r[SYNC_STAGES-2:0], cs_n};
      rw_sync_r   <= {rw_sync_r[SYNC_STAGES-2:0], rw};
      phi2_prev_r <= phi2_s;
      if (phi2_s) begin
        addr_r <= bus_addr;
        data_r <= bus_data;
      end
    end
  end

  assign wr_stb = done_s & ~rw_sync_r[SYNC_STAGES-1];
  assign rd_stb = done_s &  rw_sync_r[SYNC_STAGES-1];
  assign addr   = addr_r;
  assign data   = data_r;

endmodule

// File: rtl/gpu_sprite_regs.sv
// CPU-facing sprite registers: staging written from the 6502 bus, copied to
// the live set atomically at the start of vsync, plus vblank status and IRQ.
module gpu_sprite_regs
  import gpu_pkg::*;
#(
  parameter int   H_ACTIVE     = 800,
  parameter int   V_ACTIVE     = 600,
  parameter logic VSYNC_ACTIVE = 1'b1,
  parameter int   SYNC_STAGES  = 2,
  parameter int   INIT_X       = 20,
  parameter int   INIT_Y       = 40
) (
  input  logic                CLK_PIXEL,
  input  logic                RESET_N,
  gpu_sprite_regs_if.slave    bus,
  input  logic                VSYNC_IN,
  output logic [COORD_W-1:0]  SPRITE_X,
  output logic [COORD_W-1:0]  SPRITE_Y,
  input  logic [2:0]          ROW_SEL,
  output logic [SPRITE_W-1:0] ROW_DATA,
  output logic                IRQ_N
);

  localparam coord_t INIT_X_C = coord_t'(INIT_X);
  localparam coord_t INIT_Y_C = coord_t'(INIT_Y);

  logic        wr_stb_s, rd_stb_s, vs_start_s, commit_req_s, status_rd_s;
  logic [3:0]  acc_addr_s;
  logic [7:0]  acc_data_s, rd_data_s, status_s;
  coord_t      stg_x_r, stg_y_r, live_x_r, live_y_r;
  sprite_bmp_t stg_rows_r, live_rows_r;
  logic        irq_en_r, pending_r, vblank_r, irq_n_r, vs_r, vs_prev_r;
  logic [SPRITE_W-1:0] row_s;

  gpu_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk(CLK_PIXEL), .rst_n(RESET_N),
    .phi2(bus.PHI2), .cs_n(bus.CS_N), .rw(bus.RW),
    .bus_addr(bus.ADDR), .bus_data(bus.DATA_IN),
    .wr_stb(wr_stb_s), .rd_stb(rd_stb_s), .addr(acc_addr_s), .data(acc_data_s)
  );

  assign vs_start_s   = (vs_r == VSYNC_ACTIVE) && (vs_prev_r != VSYNC_ACTIVE);
  assign commit_req_s = wr_stb_s && (acc_addr_s == REG_CTRL) && acc_data_s[CTRL_COMMIT_BIT];
  assign status_rd_s  = rd_stb_s && (acc_addr_s == REG_STATUS);

  // CPU writes into the staging copy and the IRQ enable.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      stg_x_r    <= INIT_X_C;
      stg_y_r    <= INIT_Y_C;
      stg_rows_r <= SPRITE_DEFAULT;
      irq_en_r   <= 1'b0;
    end else if (wr_stb_s) begin
      case (acc_addr_s)
        REG_XLO:  stg_x_r[7:0]         <= acc_data_s;
        REG_XHI:  stg_x_r[COORD_W-1:8] <= acc_data_s[2:0];
        REG_YLO:  stg_y_r[7:0]         <= acc_data_s;
        REG_YHI:  stg_y_r[COORD_W-1:8] <= acc_data_s[2:0];
        REG_ROW0: stg_rows_r[0]        <= acc_data_s[SPRITE_W-1:0];
        REG_ROW1: stg_rows_r[1]        <= acc_data_s[SPRITE_W-1:0];
        REG_ROW2: stg_rows_r[2]        <= acc_data_s[SPRITE_W-1:0];
        REG_ROW3: stg_rows_r[3]        <= acc_data_s[SPRITE_W-1:0];
        REG_ROW4: stg_rows_r[4]        <= acc_data_s[SPRITE_W-1:0];
        REG_CTRL: irq_en_r             <= acc_data_s[CTRL_IRQ_EN_BIT];
        default:  ;
      endcase
    end
  end

  // Vsync edge detect, atomic commit, flags and IRQ; set beats clear on collisions.
  always_ff @(posedge CLK_PIXEL or negedge RESET_N) begin
    if (!RESET_N) begin
      vs_r        <= ~VSYNC_ACTIVE;
      vs_prev_r   <= ~VSYNC_ACTIVE;
      live_x_r    <= INIT_X_C;
      live_y_r    <= INIT_Y_C;
      live_rows_r <= SPRITE_DEFAULT;
      pending_r   <= 1'b0;
      vblank_r    <= 1'b0;
      irq_n_r     <= 1'b1;
    end else begin
      vs_r      <= VSYNC_IN;
      vs_prev_r <= vs_r;
      if (vs_start_s && pending_r) begin
        live_x_r    <= wrap_coord(stg_x_r, int'(unsigned'(H_ACTIVE)));
        live_y_r    <= wrap_coord(stg_y_r, int'(unsigned'(V_ACTIVE)));
        live_rows_r <= stg_rows_r;
      end
      if (commit_req_s) begin
        pending_r <= 1'b1;
      end else if (vs_start_s) begin
        pending_r <= 1'b0;
      end
      if (vs_start_s) begin
        vblank_r <= 1'b1;
      end else if (status_rd_s) begin
        vblank_r <= 1'b0;
      end
      irq_n_r <= ~(irq_en_r & vblank_r);
    end
  end

  // Status byte assembled from the flags.
  always_comb begin
    status_s                   = 8'h00;
    status_s[STAT_PENDING_BIT] = pending_r;
    status_s[STAT_VBLANK_BIT]  = vblank_r;
    status_s[STAT_IRQ_BIT]     = ~irq_n_r;
  end

  // Read mux follows the raw address pins so data is valid within the PHI2 high phase.
  always_comb begin
    rd_data_s = 8'h00;
    case (bus.ADDR)
      REG_XLO:    rd_data_s = stg_x_r[7:0];
      REG_XHI:    rd_data_s = {5'b00000, stg_x_r[COORD_W-1:8]};
      REG_YLO:    rd_data_s = stg_y_r[7:0];
      REG_YHI:    rd_data_s = {5'b00000, stg_y_r[COORD_W-1:8]};
      REG_ROW0:   rd_data_s = {3'b000, stg_rows_r[0]};
      REG_ROW1:   rd_data_s = {3'b000, stg_rows_r[1]};
      REG_ROW2:   rd_data_s = {3'b000, stg_rows_r[2]};
      REG_ROW3:   rd_data_s = {3'b000, stg_rows_r[3]};
      REG_ROW4:   rd_data_s = {3'b000, stg_rows_r[4]};
      REG_CTRL:   rd_data_s = {6'b000000, irq_en_r, pending_r};
      REG_STATUS: rd_data_s = status_s;
      default:    rd_data_s = 8'h00;
    endcase
  end

  // Live row lookup for the pixel path.
  always_comb begin
    row_s = {SPRITE_W{1'b0}};
    if (ROW_SEL <= 3'd4) begin
      row_s = live_rows_r[ROW_SEL];
    end else begin
      row_s = {SPRITE_W{1'b0}};
    end
  end

  assign bus.DATA_OUT = rd_data_s;
  assign bus.DATA_OE  = ~bus.CS_N & bus.RW & bus.PHI2;
  assign SPRITE_X     = live_x_r;
  assign SPRITE_Y     = live_y_r;
  assign ROW_DATA     = row_s;
  assign IRQ_N        = irq_n_r;

endmodule

// File: tb/tb_gpu_sprite_regs.sv
// Self-checking bench for gpu_sprite_regs: reset table, scripted register
// table, hand-written collision sequences and random ops against a model.
module tb_gpu_sprite_regs;

  localparam int SYNC_STAGES = 2;
  // PHI2 fall reaches the register file after SYNC_STAGES+1 edges, a VSYNC
  // rise after 2; raising VSYNC this many cycles later makes them coincide.
  localparam int PHI2_TO_VS  = SYNC_STAGES - 1;

  logic        CLK_PIXEL = 1'b0;
  logic        RESET_N;
  logic        VSYNC_IN;
  logic [10:0] SPRITE_X, SPRITE_Y;
  logic [2:0]  ROW_SEL;
  logic [4:0]  ROW_DATA;
  logic        IRQ_N;

  gpu_sprite_regs_if bus();

  gpu_sprite_regs #(
    .H_ACTIVE(800), .V_ACTIVE(600), .VSYNC_ACTIVE(1'b1),
    .SYNC_STAGES(SYNC_STAGES), .INIT_X(20), .INIT_Y(40)
  ) dut (
    .CLK_PIXEL(CLK_PIXEL), .RESET_N(RESET_N), .bus(bus),
    .VSYNC_IN(VSYNC_IN), .SPRITE_X(SPRITE_X), .SPRITE_Y(SPRITE_Y),
    .ROW_SEL(ROW_SEL), .ROW_DATA(ROW_DATA), .IRQ_N(IRQ_N)
  );

  always #5 CLK_PIXEL = ~CLK_PIXEL;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: register contents as plain integers.
  int unsigned m_stg_x, m_stg_y, m_live_x, m_live_y;
  int unsigned m_stg_row[5];
  int unsigned m_live_row[5];
  bit m_pending, m_vblank, m_irq_en;

  function automatic void m_reset();
    m_stg_x = 20; m_live_x = 20; m_stg_y = 40; m_live_y = 40;
    m_stg_row  = '{16, 16, 31, 17, 17};
    m_live_row = '{16, 16, 31, 17, 17};
    m_pending = 1'b0; m_vblank = 1'b0; m_irq_en = 1'b0;
  endfunction

  function automatic logic [7:0] m_read(input logic [3:0] a);
    int v;
    v = 0;
    case (int'(a))
      0: v = m_stg_x % 256;
      1: v = m_stg_x / 256;
      2: v = m_stg_y % 256;
      3: v = m_stg_y / 256;
      4, 5, 6, 7, 8: v = m_stg_row[int'(a) - 4];
      10: v = ((m_irq_en && m_vblank) ? 128 : 0) + (m_vblank ? 2 : 0) + (m_pending ? 1 : 0);
      default: v = 0;
    endcase
    return 8'(v);
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [7:0] d);
    case (int'(a))
      0: m_stg_x = (m_stg_x / 256) * 256 + d;
      1: m_stg_x = (d % 8) * 256 + m_stg_x % 256;
      2: m_stg_y = (m_stg_y / 256) * 256 + d;
      3: m_stg_y = (d % 8) * 256 + m_stg_y % 256;
      4, 5, 6, 7, 8: m_stg_row[int'(a) - 4] = d % 32;
      9: begin
        m_irq_en = ((d / 2) % 2) == 1;
        if (d % 2 == 1) m_pending = 1'b1;
      end
      default: ;
    endcase
  endfunction

  function automatic void m_vsync();
    m_vblank = 1'b1;
    if (m_pending) begin
      m_live_x = (m_stg_x >= 800) ? 0 : m_stg_x;
      m_live_y = (m_stg_y >= 600) ? 0 : m_stg_y;
      for (int i = 0; i < 5; i++) m_live_row[i] = m_stg_row[i];
      m_pending = 1'b0;
    end
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  // One 6502 bus cycle; with_vs raises VSYNC so vs_start meets the access completion.
  task automatic bus_op(input logic rw, input logic [3:0] a, input logic [7:0] d,
                        input logic with_vs, output logic [7:0] rd, output logic oe,
                        output logic [7:0] exp_rd);
    exp_rd = m_read(a);
    @(negedge CLK_PIXEL);
    bus.ADDR = a; bus.DATA_IN = d; bus.RW = rw; bus.CS_N = 1'b0;
    @(negedge CLK_PIXEL);
    bus.PHI2 = 1'b1;
    repeat ($urandom_range(7, 4)) @(negedge CLK_PIXEL);
    rd = bus.DATA_OUT; oe = bus.DATA_OE;
    bus.PHI2 = 1'b0;
    if (with_vs) begin
      repeat (PHI2_TO_VS) @(negedge CLK_PIXEL);
      VSYNC_IN = 1'b1;
    end
    repeat (5) @(negedge CLK_PIXEL);
    bus.CS_N = 1'b1; bus.RW = 1'b1; VSYNC_IN = 1'b0;
    repeat (3) @(negedge CLK_PIXEL);
    if (rw && a == 4'hA) m_vblank = 1'b0;
    if (with_vs) m_vsync();
    if (!rw) m_write(a, d);
  endtask

  task automatic vsync_pulse();
    @(negedge CLK_PIXEL);
    VSYNC_IN = 1'b1;
    repeat (3) @(negedge CLK_PIXEL);
    VSYNC_IN = 1'b0;
    repeat (3) @(negedge CLK_PIXEL);
    m_vsync();
  endtask

  task automatic chk_outputs(input string tag);
    int sel;
    sel = $urandom_range(7, 0);
    ROW_SEL = 3'(sel);
    #1;
    chk({tag, "_x"}, 32'(SPRITE_X), m_live_x);
    chk({tag, "_y"}, 32'(SPRITE_Y), m_live_y);
    chk({tag, "_irq_n"}, 32'(IRQ_N), (m_irq_en && m_vblank) ? 0 : 1);
    chk({tag, "_row"}, 32'(ROW_DATA), (sel < 5) ? m_live_row[sel] : 0);
  endtask

  typedef struct {
    logic [2:0] sel;
    logic [4:0] exp;
  } row_vec_t;

  typedef struct {
    logic        rw;
    logic [3:0]  addr;
    logic [7:0]  wdata;
    logic        vs;
    logic [7:0]  exp_rd;
    logic [10:0] exp_x;
    logic [10:0] exp_y;
  } vec_t;

  row_vec_t rvecs[8];
  vec_t     vecs[16];

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rd, er;
    logic oe;
    int lat;

    rvecs[0] = '{3'd0, 5'b10000}; rvecs[1] = '{3'd1, 5'b10000};
    rvecs[2] = '{3'd2, 5'b11111}; rvecs[3] = '{3'd3, 5'b10001};
    rvecs[4] = '{3'd4, 5'b10001}; rvecs[5] = '{3'd5, 5'b00000};
    rvecs[6] = '{3'd6, 5'b00000}; rvecs[7] = '{3'd7, 5'b00000};

    vecs[0]  = '{1'b0, 4'h0, 8'h2C, 1'b0, 8'h00, 11'd20,  11'd40};
    vecs[1]  = '{1'b0, 4'h1, 8'h01, 1'b0, 8'h00, 11'd20,  11'd40};
    vecs[2]  = '{1'b0, 4'h2, 8'h00, 1'b0, 8'h00, 11'd20,  11'd40};
    vecs[3]  = '{1'b0, 4'h3, 8'h01, 1'b0, 8'h00, 11'd20,  11'd40};
    vecs[4]  = '{1'b0, 4'h9, 8'h01, 1'b0, 8'h00, 11'd20,  11'd40};
    vecs[5]  = '{1'b1, 4'hA, 8'h00, 1'b1, 8'h01, 11'd300, 11'd256};
    vecs[6]  = '{1'b1, 4'hA, 8'h00, 1'b0, 8'h02, 11'd300, 11'd256};
    vecs[7]  = '{1'b1, 4'hA, 8'h00, 1'b0, 8'h00, 11'd300, 11'd256};
    vecs[8]  = '{1'b0, 4'h0, 8'h20, 1'b0, 8'h00, 11'd300, 11'd256};
    vecs[9]  = '{1'b0, 4'h1, 8'h03, 1'b0, 8'h00, 11'd300, 11'd256};
    vecs[10] = '{1'b0, 4'h2, 8'h58, 1'b0, 8'h00, 11'd300, 11'd256};
    vecs[11] = '{1'b0, 4'h3, 8'h02, 1'b0, 8'h00, 11'd300, 11'd256};
    vecs[12] = '{1'b0, 4'h9, 8'h01, 1'b1, 8'h00, 11'd0,   11'd0};
    vecs[13] = '{1'b1, 4'h0, 8'h00, 1'b0, 8'h20, 11'd0,   11'd0};
    vecs[14] = '{1'b1, 4'h1, 8'h00, 1'b0, 8'h03, 11'd0,   11'd0};
    vecs[15] = '{1'b1, 4'hA, 8'h00, 1'b0, 8'h02, 11'd0,   11'd0};

    RESET_N = 1'b0; VSYNC_IN = 1'b0; ROW_SEL = 3'd0;
    bus.PHI2 = 1'b0; bus.CS_N = 1'b1; bus.RW = 1'b1; bus.ADDR = 4'h0; bus.DATA_IN = 8'h00;
    m_reset();
    repeat (4) @(negedge CLK_PIXEL);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_PIXEL);

    // Reset state
    chk("rst_x", 32'(SPRITE_X), 32'd20);
    chk("rst_y", 32'(SPRITE_Y), 32'd40);
    chk("rst_irq_n", 32'(IRQ_N), 32'd1);
    chk("rst_oe", 32'(bus.DATA_OE), 32'd0);
    for (int i = 0; i < 8; i++) begin
      ROW_SEL = rvecs[i].sel;
      #1;
      chk("rst_row", 32'(ROW_DATA), 32'(rvecs[i].exp));
    end

    // Scripted register sequence
    for (int i = 0; i < 16; i++) begin
      bus_op(vecs[i].rw, vecs[i].addr, vecs[i].wdata, 1'b0, rd, oe, er);
      if (vecs[i].vs) vsync_pulse();
      chk("tbl_oe", 32'(oe), 32'(vecs[i].rw));
      if (vecs[i].rw) chk("tbl_rd", 32'(rd), 32'(vecs[i].exp_rd));
      chk("tbl_x", 32'(SPRITE_X), 32'(vecs[i].exp_x));
      chk("tbl_y", 32'(SPRITE_Y), 32'(vecs[i].exp_y));
    end
    chk("idle_oe", 32'(bus.DATA_OE), 32'd0);

    // Row write without commit request stays in staging across vsyncs
    bus_op(1'b0, 4'h6, 8'h15, 1'b0, rd, oe, er);
    ROW_SEL = 3'd2;
    for (int i = 0; i < 3; i++) begin
      vsync_pulse();
      chk("row2_hold", 32'(ROW_DATA), 32'h1F);
    end
    bus_op(1'b0, 4'h9, 8'h01, 1'b0, rd, oe, er);
    vsync_pulse();
    ROW_SEL = 3'd2; #1;
    chk("row2_commit", 32'(ROW_DATA), 32'h15);

    // IRQ follows VBLANK by one cycle
    bus_op(1'b1, 4'hA, 8'h00, 1'b0, rd, oe, er);
    bus_op(1'b0, 4'h9, 8'h02, 1'b0, rd, oe, er);
    chk("irq_idle", 32'(IRQ_N), 32'd1);
    @(negedge CLK_PIXEL);
    VSYNC_IN = 1'b1;
    lat = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge CLK_PIXEL);
      if (!IRQ_N && lat == 0) lat = k;
    end
    VSYNC_IN = 1'b0;
    repeat (3) @(negedge CLK_PIXEL);
    m_vsync();
    chk("irq_latency", 32'(lat), 32'd3);
    bus_op(1'b1, 4'hA, 8'h00, 1'b0, rd, oe, er);
    chk("irq_status", 32'(rd), 32'h82);
    chk("irq_cleared", 32'(IRQ_N), 32'd1);

    // Commit request landing on vs_start: commit happens, request survives
    bus_op(1'b0, 4'h0, 8'h55, 1'b0, rd, oe, er);
    bus_op(1'b0, 4'h1, 8'h00, 1'b0, rd, oe, er);
    bus_op(1'b0, 4'h9, 8'h01, 1'b0, rd, oe, er);
    bus_op(1'b0, 4'h9, 8'h01, 1'b1, rd, oe, er);
    chk("coll_commit_x", 32'(SPRITE_X), 32'd85);
    bus_op(1'b1, 4'hA, 8'h00, 1'b0, rd, oe, er);
    chk("coll_pending", 32'(rd), 32'h03);

    // STATUS read landing on vs_start: VBLANK stays set
    bus_op(1'b1, 4'hA, 8'h00, 1'b1, rd, oe, er);
    chk("coll_rd_val", 32'(rd), 32'h01);
    bus_op(1'b1, 4'hA, 8'h00, 1'b0, rd, oe, er);
    chk("coll_vblank", 32'(rd), 32'h02);

    // Random ops against the model
    for (int n = 0; n < 60; n++) begin
      int op;
      logic [3:0] a;
      logic [7:0] d;
      logic wv;
      op = $urandom_range(9, 0);
      d  = 8'($urandom);
      wv = ($urandom_range(3, 0) == 0);
      if (op < 4) begin
        a = 4'($urandom);
        bus_op(1'b0, a, d, wv, rd, oe, er);
      end else if (op < 6) begin
        bus_op(1'b0, 4'h9, d, wv, rd, oe, er);
      end else if (op < 8) begin
        a = 4'($urandom);
        if (a == 4'h9) a = 4'hA;
        bus_op(1'b1, a, d, wv, rd, oe, er);
        chk("rnd_rd", 32'(rd), 32'(er));
      end else begin
        vsync_pulse();
      end
      chk_outputs("rnd");
    end

    // Reset in the middle of a write drops the access
    @(negedge CLK_PIXEL);
    bus.ADDR = 4'h0; bus.DATA_IN = 8'hAA; bus.RW = 1'b0; bus.CS_N = 1'b0;
    @(negedge CLK_PIXEL);
    bus.PHI2 = 1'b1;
    repeat (4) @(negedge CLK_PIXEL);
    RESET_N = 1'b0;
    bus.PHI2 = 1'b0;
    repeat (3) @(negedge CLK_PIXEL);
    bus.CS_N = 1'b1; bus.RW = 1'b1;
    @(negedge CLK_PIXEL);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLK_PIXEL);
    m_reset();
    bus_op(1'b1, 4'h0, 8'h00, 1'b0, rd, oe, er);
    chk("rst_mid_xlo", 32'(rd), 32'h14);
    chk("rst_mid_x", 32'(SPRITE_X), 32'd20);
    chk("rst_mid_irq_n", 32'(IRQ_N), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
